// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60), derived totals and FSM state type.
// Used by the timing generator and anything downstream that needs the geometry.
package vga_timing_pkg;

  localparam int unsigned PosW = 10;
  localparam int unsigned FcW  = 8;

  localparam int unsigned DefHDisplay = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVDisplay = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;

  localparam int unsigned DefHTotal = DefHDisplay + DefHFront + DefHSync + DefHBack;
  localparam int unsigned DefVTotal = DefVDisplay + DefVFront + DefVSync + DefVBack;

  typedef enum logic [0:0] {StIdle, StRun} vga_state_e;

  // Half-open window test: lo <= pos < hi.
  function automatic logic in_window(logic [PosW-1:0] pos, logic [PosW-1:0] lo,
                                     logic [PosW-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bus between the VGA timing generator (master) and its consumers (slave).
interface vga_timing_gen_if;

  logic                                 ena;
  logic [vga_timing_pkg::PosW-1:0]      hpos;
  logic [vga_timing_pkg::PosW-1:0]      vpos;
  logic                                 hsync;
  logic                                 vsync;
  logic                                 display_on;
  logic                                 line_start;
  logic                                 frame_start;
  logic [vga_timing_pkg::FcW-1:0]       frame_cnt;

  modport master (
    input  ena,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );

  modport slave (
    output ena,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: position counters plus registered sync/blank decode.
// Decode is taken from the next position so every output lines up with hpos/vpos.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DefHDisplay,
  parameter int unsigned H_FRONT   = DefHFront,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BACK    = DefHBack,
  parameter int unsigned V_DISPLAY = DefVDisplay,
  parameter int unsigned V_FRONT   = DefVFront,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BACK    = DefVBack
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [PosW-1:0] HLast    = PosW'(H_TOTAL - 1);
  localparam logic [PosW-1:0] VLast    = PosW'(V_TOTAL - 1);
  localparam logic [PosW-1:0] HDispEnd = PosW'(H_DISPLAY);
  localparam logic [PosW-1:0] VDispEnd = PosW'(V_DISPLAY);
  localparam logic [PosW-1:0] HSyncLo  = PosW'(H_DISPLAY + H_FRONT);
  localparam logic [PosW-1:0] HSyncHi  = PosW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [PosW-1:0] VSyncLo  = PosW'(V_DISPLAY + V_FRONT);
  localparam logic [PosW-1:0] VSyncHi  = PosW'(V_DISPLAY + V_FRONT + V_SYNC);

  vga_state_e       state_q;
  logic [PosW-1:0]  hpos_q, hpos_d;
  logic [PosW-1:0]  vpos_q, vpos_d;
  logic             frame_wrap;
  logic             hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q;
  logic [FcW-1:0]   frame_cnt_q;

  always_comb begin
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    frame_wrap = 1'b0;
    if (state_q == StIdle) begin
      hpos_d = '0;
      vpos_d = '0;
    end else if (hpos_q == HLast) begin
      hpos_d = '0;
      if (vpos_q == VLast) begin
        vpos_d     = '0;
        frame_wrap = 1'b1;
      end else begin
        vpos_d = vpos_q + 1'b1;
      end
    end else begin
      hpos_d = hpos_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hpos_q        <= '0;
      vpos_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (bus.ena) begin
      state_q       <= StRun;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= ~in_window(hpos_d, HSyncLo, HSyncHi);
      vsync_q       <= ~in_window(vpos_d, VSyncLo, VSyncHi);
      display_on_q  <= (hpos_d < HDispEnd) && (vpos_d < VDispEnd);
      line_start_q  <= (hpos_d == '0);
      frame_start_q <= (hpos_d == '0) && (vpos_d == '0);
      // The IDLE->RUN load lands on (0,0) but is not a completed frame.
      if (frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.display_on  = display_on_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-geometry instance,
// both checked every cycle against an enabled-edge-count model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } vout_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if bus_d ();
  vga_timing_gen_if bus_s ();
  assign bus_d.ena = ena;
  assign bus_s.ena = ena;

  vga_timing_gen u_dut_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_d)
  );

  vga_timing_gen #(
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (2),
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1)
  ) u_dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  vout_t act_d, act_s;
  assign act_d = {bus_d.hpos, bus_d.vpos, bus_d.hsync, bus_d.vsync, bus_d.display_on,
                  bus_d.line_start, bus_d.frame_start, bus_d.frame_cnt};
  assign act_s = {bus_s.hpos, bus_s.vpos, bus_s.hsync, bus_s.vsync, bus_s.display_on,
                  bus_s.line_start, bus_s.frame_start, bus_s.frame_cnt};

  // Geometry per instance: index 0 = default, 1 = small.
  int HD[2] = '{DefHDisplay, 8};
  int HF[2] = '{DefHFront, 2};
  int HS[2] = '{DefHSync, 3};
  int HB[2] = '{DefHBack, 2};
  int VD[2] = '{DefVDisplay, 4};
  int VF[2] = '{DefVFront, 1};
  int VS[2] = '{DefVSync, 2};
  int VB[2] = '{DefVBack, 1};

  // Model state: t counts enabled edges since the IDLE->RUN edge.
  bit     started[2];
  longint t[2];
  bit     pen[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        started[i] <= 1'b0;
        t[i]       <= 0;
        pen[i]     <= 1'b0;
      end else if (ena) begin
        if (!started[i]) begin
          started[i] <= 1'b1;
          t[i]       <= 0;
        end else begin
          t[i] <= t[i] + 1;
        end
        pen[i] <= 1'b1;
      end else begin
        pen[i] <= 1'b0;
      end
    end
  end

  function automatic vout_t mk(int h, int v, bit hs, bit vs, bit de, bit ls, bit fs, int fc);
    vout_t r;
    r.h  = 10'(h);
    r.v  = 10'(v);
    r.hs = hs;
    r.vs = vs;
    r.de = de;
    r.ls = ls;
    r.fs = fs;
    r.fc = 8'(fc);
    return r;
  endfunction

  function automatic vout_t model(int i);
    longint ht, vt;
    int     h, v, fc;
    if (!started[i]) return mk(0, 0, 1, 1, 0, 0, 0, 0);
    ht = longint'(HD[i] + HF[i] + HS[i] + HB[i]);
    vt = longint'(VD[i] + VF[i] + VS[i] + VB[i]);
    h  = int'(t[i] % ht);
    v  = int'((t[i] / ht) % vt);
    fc = int'((t[i] / (ht * vt)) % 256);
    return mk(h, v,
              !(h >= HD[i] + HF[i] && h < HD[i] + HF[i] + HS[i]),
              !(v >= VD[i] + VF[i] && v < VD[i] + VF[i] + VS[i]),
              (h < HD[i]) && (v < VD[i]),
              pen[i] && (h == 0),
              pen[i] && (h == 0) && (v == 0),
              fc);
  endfunction

  task automatic check(string name, logic [39:0] actual, logic [39:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_def", 40'(act_d), 40'(model(0)));
    check("model_small", 40'(act_s), 40'(model(1)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_low, first_low, de_fall, ls_at, vfirst_h, vfirst_v;

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    repeat (3) step();
    check("reset_state", 40'(act_d), 40'(mk(0, 0, 1, 1, 0, 0, 0, 0)));

    // First enabled edge loads (0,0) with both pulses.
    rst_n = 1'b1;
    ena   = 1'b1;
    step();
    check("first_edge", 40'(act_d), 40'(mk(0, 0, 1, 1, 1, 1, 1, 0)));
    check("first_edge_small", 40'(act_s), 40'(mk(0, 0, 1, 1, 1, 1, 1, 0)));
    step();
    check("second_edge", 40'(act_d), 40'(mk(1, 0, 1, 1, 1, 0, 0, 0)));

    // Rest of line 0 on the default instance.
    n_low = 0; first_low = -1; de_fall = -1; ls_at = -1;
    for (int k = 2; k <= 800; k++) begin
      step();
      if (!bus_d.hsync) begin
        n_low++;
        if (first_low < 0) first_low = int'(bus_d.hpos);
      end
      if (!bus_d.display_on && de_fall < 0) de_fall = int'(bus_d.hpos);
      if (bus_d.line_start && ls_at < 0) ls_at = k;
    end
    check("hsync_width", 40'(n_low), 40'd96);
    check("hsync_start", 40'(first_low), 40'd656);
    check("de_fall_hpos", 40'(de_fall), 40'd640);
    check("line1_start_cycle", 40'(ls_at), 40'd800);
    check("line1_vpos", 40'(bus_d.vpos), 40'd1);

    // Hold at hpos=655 with ena low.
    for (int k = 0; k < 800 && bus_d.hpos != 10'd655; k++) step();
    check("reach_655", 40'(act_d), 40'(mk(655, 1, 1, 1, 0, 0, 0, 0)));
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_655", 40'(act_d), 40'(mk(655, 1, 1, 1, 0, 0, 0, 0)));
    end
    ena = 1'b1;
    step();
    check("resume_656", 40'(act_d), 40'(mk(656, 1, 0, 1, 0, 0, 0, 0)));

    // Asynchronous reset mid-line, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_def", 40'(act_d), 40'(mk(0, 0, 1, 1, 0, 0, 0, 0)));
    check("async_rst_small", 40'(act_s), 40'(mk(0, 0, 1, 1, 0, 0, 0, 0)));
    repeat (2) step();

    // Restart and run one small frame (15x8 = 120 cycles).
    rst_n = 1'b1;
    step();
    check("restart_small", 40'(act_s), 40'(mk(0, 0, 1, 1, 1, 1, 1, 0)));
    check("restart_def", 40'(act_d), 40'(mk(0, 0, 1, 1, 1, 1, 1, 0)));
    n_low = 0; vfirst_h = -1; vfirst_v = -1;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (!bus_s.vsync) begin
        n_low++;
        if (vfirst_v < 0) begin
          vfirst_v = int'(bus_s.vpos);
          vfirst_h = int'(bus_s.hpos);
        end
      end
    end
    check("frame1_wrap", 40'(act_s), 40'(mk(0, 0, 1, 1, 1, 1, 1, 1)));
    check("vsync_width", 40'(n_low), 40'd30);
    check("vsync_start_v", 40'(vfirst_v), 40'd5);
    check("vsync_start_h", 40'(vfirst_h), 40'd0);

    // Run to frame_cnt=255, then one more frame wraps it to 0.
    for (int k = 0; k < 40000 && !(bus_s.frame_cnt == 8'd255 && bus_s.frame_start); k++) step();
    check("reach_255", 40'(act_s), 40'(mk(0, 0, 1, 1, 1, 1, 1, 255)));
    repeat (120) step();
    check("fc_wrap", 40'(act_s), 40'(mk(0, 0, 1, 1, 1, 1, 1, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004 Parameter H_BACK, 48, horizontal back porch in clocks.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 clk  input  1  pixel clock; one clock is one pixel.
REQ-010 rst_n  input  1  reset, asynchronous, active-low.
REQ-011 ena  input  1  advance enable; counters and outputs hold when 0.
REQ-012 hpos  output  10  current pixel column, 0..H_TOTAL-1.
REQ-013 vpos  output  10  current line, 0..V_TOTAL-1.
REQ-014 hsync  output  1  horizontal sync, active-low.
REQ-015 vsync  output  1  vertical sync, active-low.
REQ-016 display_on  output  1  high when (hpos,vpos) is in the visible area.
REQ-017 line_start  output  1  one-cycle pulse when hpos becomes 0.
REQ-018 frame_start  output  1  one-cycle pulse when (hpos,vpos) becomes (0,0).
REQ-019 frame_cnt  output  8  completed-frame count, modulo 256.

Function
REQ-020 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800) and V_TOTAL = sum of V terms (default 525) SHALL be derived, not separate parameters.
REQ-021 The block SHALL have a two-state FSM: IDLE (entered on reset) and RUN.
REQ-022 In IDLE, the first edge with ena=1 SHALL load position (0,0), drive display_on=1, line_start=1, frame_start=1, and move to RUN; frame_cnt SHALL NOT increment.
REQ-023 In RUN, each edge with ena=1 SHALL increment hpos; at hpos=H_TOTAL-1 it SHALL wrap to 0 and increment vpos.
REQ-024 At (H_TOTAL-1,V_TOTAL-1), the next enabled edge SHALL wrap to (0,0) and increment frame_cnt, with 255 wrapping to 0.
REQ-025 All outputs SHALL be registered and SHALL describe the position held in hpos/vpos in the same cycle, with zero skew between them.
REQ-026 hsync SHALL be 0 exactly when H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (default 656..751).
REQ-027 vsync SHALL be 0 exactly when V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (default 490..491).
REQ-028 display_on SHALL be 1 exactly when hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-029 line_start and frame_start SHALL be high only in the cycle after the enabled edge that produced the qualifying position; an edge with ena=0 SHALL clear them.
REQ-030 With ena=0, hpos, vpos, hsync, vsync, display_on, frame_cnt and FSM state SHALL hold.

Reset
REQ-031 While rst_n=0, outputs SHALL be hpos=0, vpos=0, hsync=1, vsync=1, display_on=0, line_start=0, frame_start=0, frame_cnt=0, and the FSM SHALL be in IDLE, asynchronously.
REQ-032 A reset asserted mid-frame SHALL abandon the frame; after release, the sequence SHALL restart per REQ-022.

Structure
REQ-033 Default timing constants and derived totals SHALL live in shared package vga_timing_pkg, for reuse by the pixel generator and the top level.
REQ-034 The block SHALL be a single module with no sub-module; counters and decode SHALL be in one always block plus registered decode.

Verification
REQ-035 Assert rst_n=0 mid-line -> all outputs match REQ-031 immediately, without waiting for a clock edge.
REQ-036 Release reset, ena=1 -> first edge gives (0,0), display_on=1, frame_start=1, line_start=1, frame_cnt=0; the next edge gives hpos=1 with both pulses 0.
REQ-037 Run one line -> hsync=0 for exactly 96 cycles starting at hpos=656; display_on falls at hpos=640; line 1 starts 800 cycles after line 0.
REQ-038 Run 420000 enabled cycles from (0,0) -> back at (0,0), frame_cnt=1, frame_start pulse; vsync=0 for exactly 1600 cycles starting at vpos=490, hpos=0.
REQ-039 Drop ena for 5 cycles at hpos=655 -> all counters and syncs hold; hsync falls on the first enabled edge after ena returns.
REQ-040 Force frame_cnt to 255 via 256 frames (or reduced-size parameters) -> the next wrap gives frame_cnt=0.
